uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver, in the `rx_clk` domain. It captures each completed frame on the rising edge of the receiver's `done`, together with its `data_out`, `framing_error` and `parity_error`. It stores frames in a first-in first-out buffer and presents them to the host through a valid/ready read port. It also provides occupancy, watermark and sticky overflow status.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo_mem.sv | 33 +++
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side FIFO.
//   ptr_width()   : FIFO pointer width, one extra bit beyond the address so
//                   that full and empty can be told apart.
//   TAG_BITS      : error-tag bits stored per entry (0 or 2).
//   entry_width() : stored entry width for a given payload width.
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN. When it is defined, the
// framing and parity error tags are stored with each frame.
package uart_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int TAG_BITS = 2;
`else
    localparam int TAG_BITS = 0;
`endif

    function automatic int entry_width(input int data_width);
        return data_width + TAG_BITS;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array memory for the UART receive-side FIFO.
// It has one synchronous write port and one asynchronous read port.
// The contents are not reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO that sits directly downstream of the UART receiver.
// It captures one frame on each rising edge of the receiver's done signal
// and presents the frames to the host through a show-ahead valid/ready port.
// Ports:
//   rx_clk, rst (async, active-low)
//   wr_done, wr_data, wr_framing_error, wr_parity_error : receiver side
//   rd_ready, clr_overflow                              : host controls
//   rd_valid, rd_data, rd_framing_error, rd_parity_error: head entry
//   count, full, empty, almost_full, overflow           : status
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN.
//   Defined     : the error tags are stored with each entry.
//   Not defined : errored frames are discarded, and the rd_* tags are tied to 0.
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                     rx_clk,
    input  logic                     rst,
    input  logic                     wr_done,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_framing_error,
    input  logic                     wr_parity_error,
    input  logic                     rd_ready,
    input  logic                     clr_overflow,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_framing_error,
    output logic                     rd_parity_error,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int EW = entry_width(DATA_WIDTH);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LEVEL);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          done_q;
    logic          wr_evt;
    logic          frame_ok;
    logic          pop;
    logic          wr_acc;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign wr_evt = wr_done & ~done_q;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign frame_ok         = 1'b1;
    assign wr_entry         = {wr_framing_error, wr_parity_error, wr_data};
    assign rd_data          = rd_entry[DATA_WIDTH-1:0];
    assign rd_parity_error  = rd_entry[DATA_WIDTH];
    assign rd_framing_error = rd_entry[DATA_WIDTH+1];
`else
    assign frame_ok         = ~(wr_framing_error | wr_parity_error);
    assign wr_entry         = wr_data;
    assign rd_data          = rd_entry;
    assign rd_parity_error  = 1'b0;
    assign rd_framing_error = 1'b0;
`endif

    // Pointer difference wraps modulo 2*DEPTH, which gives the true occupancy.
    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AFULL_C);
    assign rd_valid    = ~empty;

    assign pop = rd_valid & rd_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot for the write.
    assign wr_acc = wr_evt & frame_ok & (~full | pop);
    assign drop   = wr_evt & frame_ok & full & ~pop;

    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done_q <= wr_done;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (rx_clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic          rx_clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_done = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_framing_error = 1'b0;
    logic          wr_parity_error = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_framing_error;
    logic          rd_parity_error;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of {framing, parity, data} frames, the sticky
    // overflow bit, and the last observed level of done.
    logic [DW+1:0] mq[$];
    bit            m_ovf  = 1'b0;
    bit            m_prev = 1'b0;

    always #5 rx_clk = ~rx_clk;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .rx_clk           (rx_clk),
        .rst              (rst),
        .wr_done          (wr_done),
        .wr_data          (wr_data),
        .wr_framing_error (wr_framing_error),
        .wr_parity_error  (wr_parity_error),
        .rd_ready         (rd_ready),
        .clr_overflow     (clr_overflow),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_framing_error (rd_framing_error),
        .rd_parity_error  (rd_parity_error),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .overflow         (overflow)
    );

    // Advance one clock edge. The model is updated using the inputs seen at that edge.
    task automatic tick();
        bit ev;
        bit pop;
        bit drop;
        if (rst) begin
            pop  = (mq.size() > 0) && rd_ready;
            ev   = wr_done && !m_prev;
            drop = 1'b0;
            if (pop) void'(mq.pop_front());
            if (ev && (TAG_EN || !(wr_framing_error || wr_parity_error))) begin
                if (mq.size() < DEPTH)
                    mq.push_back({wr_framing_error, wr_parity_error, wr_data});
                else
                    drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            m_prev = wr_done;
        end
        @(posedge rx_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit fe, input bit pe);
        wr_data = d;
        wr_framing_error = fe;
        wr_parity_error = pe;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        wr_framing_error = 1'b0;
        wr_parity_error = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_prev = 1'b0;
        #3;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_tests++;
        if ({rd_valid, empty, full, almost_full, overflow, count} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_idle: valid/empty/full/af/ovf/count = %b%b%b%b%b %0d, required 01000 0",
                     rd_valid, empty, full, almost_full, overflow, count);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp [3];
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
        wr_data = 8'hA5;
        wr_done = 1'b1;
        tick();
        n_tests++;
        if (rd_valid !== 1'b1 || count !== 5'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL first_write_latency: valid %b count %0d empty %b, required 1 1 0", rd_valid, count, empty);
        end
        wr_done = 1'b0;
        tick();
        send(8'h3C, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_head%0d: valid %b data %h, required 1 %h", i, rd_valid, rd_data, exp[i]);
            end
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        n_tests++;
        if (empty !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_empty: empty %b valid %b, required 1 0", empty, rd_valid);
        end
    endtask

    task automatic test_hold();
        wr_data = 8'h55;
        wr_done = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        wr_done = 1'b0;
        tick();
        n_tests++;
        if (count !== 5'd1 || rd_data !== 8'h55) begin
            n_fail++;
            $display("FAIL hold_single_write: count %0d data %h, required 1 55", count, rd_data);
        end
        drain();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            send(8'($urandom), 1'b0, 1'b0);
            n_tests++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= AFULL) || full !== (i + 1 == DEPTH)) begin
                n_fail++;
                $display("FAIL fill_level%0d: count %0d af %b full %b, required %0d %b %b",
                         i + 1, count, almost_full, full, i + 1, i + 1 >= AFULL, i + 1 == DEPTH);
            end
        end
        wr_data = 8'h77;
        wr_done = 1'b1;
        tick();
        n_tests++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_drop: ovf %b count %0d, required 1 16", overflow, count);
        end
        wr_done = 1'b0;
        tick();
        // Drop and clear in the same cycle: the set wins.
        clr_overflow = 1'b1;
        wr_done = 1'b1;
        tick();
        clr_overflow = 1'b0;
        wr_done = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set_wins: ovf %b, required 1", overflow);
        end
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: ovf %b, required 0", overflow);
        end
        // A write while full, with a pop in the same cycle, is accepted.
        wr_data = 8'hC3;
        wr_done = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_ready = 1'b0;
        n_tests++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_write_with_pop: count %0d ovf %b, required 16 0", count, overflow);
        end
        tick();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== mq[0][DW-1:0]) begin
                n_fail++;
                $display("FAIL fill_drain%0d: valid %b data %h, required 1 %h", i, rd_valid, rd_data, mq[0][DW-1:0]);
            end
            tick();
        end
        rd_ready = 1'b0;
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drain_empty: empty %b, required 1", empty);
        end
    endtask

    task automatic test_error_tag();
        send(8'h81, 1'b0, 1'b1);
        n_tests++;
        if (TAG_EN) begin
            if (rd_valid !== 1'b1 || rd_data !== 8'h81 || rd_parity_error !== 1'b1 || rd_framing_error !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_tag: valid %b data %h pe %b fe %b, required 1 81 1 0",
                         rd_valid, rd_data, rd_parity_error, rd_framing_error);
            end
        end else begin
            if (empty !== 1'b1 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_discard: empty %b ovf %b, required 1 0", empty, overflow);
            end
        end
        send(8'h42, 1'b1, 1'b0);
        n_tests++;
        if (count !== 5'(mq.size())) begin
            n_fail++;
            $display("FAIL framing_frame: count %0d, required %0d", count, mq.size());
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send(8'(i + 8'h10), 1'b0, 1'b0);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_prev = 1'b0;
        #1;
        n_tests++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: count %0d valid %b, required 0 0", count, rd_valid);
        end
        tick();
        rst = 1'b1;
        tick();
        send(8'h99, 1'b0, 1'b0);
        n_tests++;
        if (count !== 5'd1 || rd_data !== 8'h99) begin
            n_fail++;
            $display("FAIL reset_then_write: count %0d data %h, required 1 99", count, rd_data);
        end
        drain();
    endtask

    task automatic test_random();
        int rd_pct;
        for (int c = 0; c < 3000; c++) begin
            rd_pct = (c < 1000) ? 20 : (c < 2000 ? 80 : 50);
            wr_done          = ($urandom_range(0, 1) == 1);
            wr_data          = 8'($urandom);
            wr_framing_error = ($urandom_range(0, 7) == 0);
            wr_parity_error  = ($urandom_range(0, 7) == 0);
            rd_ready         = ($urandom_range(0, 99) < rd_pct);
            clr_overflow     = ($urandom_range(0, 15) == 0);
            tick();
            n_tests++;
            if (count !== 5'(mq.size()) || rd_valid !== (mq.size() > 0) || empty !== (mq.size() == 0) ||
                full !== (mq.size() == DEPTH) || almost_full !== (mq.size() >= AFULL) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_status cycle %0d: count %0d valid %b full %b af %b ovf %b, required %0d %b %b %b %b",
                         c, count, rd_valid, full, almost_full, overflow, mq.size(), mq.size() > 0,
                         mq.size() == DEPTH, mq.size() >= AFULL, m_ovf);
            end
            if (mq.size() > 0) begin
                n_tests++;
                if (rd_data !== mq[0][DW-1:0] ||
                    rd_parity_error !== (TAG_EN & mq[0][DW]) || rd_framing_error !== (TAG_EN & mq[0][DW+1])) begin
                    n_fail++;
                    $display("FAIL random_head cycle %0d: data %h fe %b pe %b, required %h %b %b", c, rd_data,
                             rd_framing_error, rd_parity_error, mq[0][DW-1:0], TAG_EN & mq[0][DW+1], TAG_EN & mq[0][DW]);
                end
            end
        end
        wr_done = 1'b0;
        wr_framing_error = 1'b0;
        wr_parity_error = 1'b0;
        clr_overflow = 1'b0;
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_fill();
        test_error_tag();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
